cam_frame_writer: RTL and testbench

//  Write-side front end of the dual-port frame buffer. Samples the camera's

---
 rtl/cam_frame_writer.sv | 164 ++++++++++++++++
 tb/tb_cam_frame_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_writer.sv
// Camera byte-stream to frame-buffer write port: packs RGB565 byte pairs into RGB332 pixels.
// Define CAM_FRAME_WRITER_TESTPAT_EN to write col^row instead of camera data.
module cam_frame_writer #(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int H_PIX = 160,
    parameter int V_PIX = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf,
    output logic          err
);

    localparam int CW = $clog2(H_PIX + 1);
    localparam int RW = $clog2(V_PIX + 1);
    localparam int BW = AW + 1;
    localparam logic [CW-1:0] H_LIM  = CW'(H_PIX);
    localparam logic [RW-1:0] V_LIM  = RW'(V_PIX);
    localparam logic [BW-1:0] H_STEP = BW'(H_PIX);

    typedef enum logic [2:0] {IDLE, WAIT_LINE, LINE_B0, LINE_B1, DONE} state_t;

    state_t        state_reg;
    logic          vsync_q;
    logic          href_q;
    logic          cap_en_q;
    logic [7:0]    data_q;
    logic          in_valid_reg;
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [BW-1:0] line_base_reg;
    logic [5:0]    b0_reg;
    logic          pend_valid_reg;
    logic [AW-1:0] pend_addr_reg;
    logic [DW-1:0] pend_data_reg;

    logic          vsync_fall;
    logic          vsync_rise;
    logic          href_rise;
    logic          pix_in_range;
    logic [DW-1:0] pix_data;

    // in_valid_reg masks the reset value of vsync_q so a low vsync at reset release is not a frame start
    assign vsync_fall   = in_valid_reg & vsync_q & ~cam_vsync;
    assign vsync_rise   = ~vsync_q & cam_vsync;
    assign href_rise    = ~href_q & cam_href;
    assign pix_in_range = (col_reg < H_LIM) && (row_reg < V_LIM);

`ifdef CAM_FRAME_WRITER_TESTPAT_EN
    assign pix_data = DW'(8'(col_reg) ^ 8'(row_reg));
`else
    assign pix_data = DW'({b0_reg[5:3], b0_reg[2:0], data_q[4:3]});
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            vsync_q        <= 1'b1;
            href_q         <= 1'b0;
            cap_en_q       <= 1'b0;
            data_q         <= '0;
            in_valid_reg   <= 1'b0;
            col_reg        <= '0;
            row_reg        <= '0;
            line_base_reg  <= '0;
            b0_reg         <= '0;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            addr_in        <= '0;
            data_in        <= '0;
            regwrite       <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            ovf            <= 1'b0;
            err            <= 1'b0;
        end else begin
            vsync_q        <= cam_vsync;
            href_q         <= cam_href;
            cap_en_q       <= cap_en;
            data_q         <= cam_data;
            in_valid_reg   <= 1'b1;
            frame_done     <= 1'b0;
            pend_valid_reg <= 1'b0;

            regwrite <= pend_valid_reg;
            if (pend_valid_reg) begin
                addr_in <= pend_addr_reg;
                data_in <= pend_data_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (vsync_fall && cap_en_q) begin
                        state_reg     <= WAIT_LINE;
                        row_reg       <= '0;
                        col_reg       <= '0;
                        line_base_reg <= '0;
                        ovf           <= 1'b0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                WAIT_LINE: begin
                    if (vsync_rise) begin
                        state_reg  <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (href_rise) begin
                        state_reg <= LINE_B0;
                    end
                end
                LINE_B0, LINE_B1: begin
                    if (!href_q) begin
                        // line end; row and line_base stop at the frame size so the address cannot wrap
                        col_reg <= '0;
                        if (row_reg < V_LIM) begin
                            row_reg       <= row_reg + 1'b1;
                            line_base_reg <= line_base_reg + H_STEP;
                        end
                        if (state_reg == LINE_B1) err <= 1'b1;
                        if (vsync_rise) begin
                            state_reg  <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else if (href_rise) begin
                            state_reg <= LINE_B0;
                        end else begin
                            state_reg <= WAIT_LINE;
                        end
                    end else if (vsync_rise) begin
                        if (state_reg == LINE_B1) err <= 1'b1;
                        state_reg  <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (state_reg == LINE_B0) begin
                        b0_reg    <= {data_q[7:5], data_q[2:0]};
                        state_reg <= LINE_B1;
                    end else begin
                        pend_data_reg <= pix_data;
                        pend_addr_reg <= AW'(line_base_reg + BW'(col_reg));
                        if (pix_in_range) pend_valid_reg <= 1'b1;
                        else              ovf            <= 1'b1;
                        if (col_reg < H_LIM) col_reg <= col_reg + 1'b1;
                        state_reg <= LINE_B0;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer: drives camera frames and compares the write stream
// against a per-frame reference model built from the pixel/line rules.
module tb_cam_frame_writer;
    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int H_PIX = 4;
    localparam int V_PIX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cap_en = 1'b0;
    logic          cam_vsync = 1'b1;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          busy;
    logic          frame_done;
    logic          ovf;
    logic          err;

    cam_frame_writer #(.AW(AW), .DW(DW), .H_PIX(H_PIX), .V_PIX(V_PIX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_base = 0;
    wr_t exp_q[$];
    wr_t got_q[$];

    // reference model state for the frame in progress
    bit  m_cap = 0;
    int  m_row = 0;
    bit  m_err = 0;
    bit  m_ovf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (regwrite) got_q.push_back('{int'(addr_in), int'(data_in), cyc});
            if (frame_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_pix(input int b0, input int b1, input int r, input int c);
`ifdef CAM_FRAME_WRITER_TESTPAT_EN
        return (c ^ r) % 256;
`else
        return ((b0 / 32) % 8) * 32 + (b0 % 8) * 4 + (b1 / 8) % 4;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(input bit cap);
        @(negedge clk);
        cap_en = cap;
        idle(3);
        cam_vsync = 1'b0;
        m_cap = cap;
        if (cap) begin
            m_row = 0;
            m_err = 0;
            m_ovf = 0;
        end
        exp_q.delete();
        got_q.delete();
        done_base = done_cnt;
        idle(3);
    endtask

    // f0/f1 >= 0 force the first byte pair; b1c returns the cycle at which byte 1 was driven
    task automatic send_line(input int n, input int f0, input int f1, output int b1c);
        logic [7:0] b [16];
        b1c = 0;
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        if (f0 >= 0) b[0] = 8'(f0);
        if (f1 >= 0) b[1] = 8'(f1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = b[i];
            if (i == 1) b1c = cyc;
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        idle(3 + $urandom_range(0, 2));
        if (m_cap) begin
            for (int p = 0; p < n / 2; p++) begin
                if (m_row < V_PIX && p < H_PIX)
                    exp_q.push_back('{m_row * H_PIX + p, ref_pix(b[2*p], b[2*p+1], m_row, p), 0});
                else
                    m_ovf = 1;
            end
            if (n % 2 == 1) m_err = 1;
            m_row++;
        end
    endtask

    task automatic frame_end(input string name);
        int n;
        @(negedge clk);
        chk({name, "_busy_mid"}, busy, m_cap);
        cam_vsync = 1'b1;
        idle(6);
        chk({name, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("%s wr%0d addr=%0d data=%02h (model addr=%0d data=%02h)",
                     name, i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            chk({name, "_addr"}, got_q[i].a, exp_q[i].a);
            chk({name, "_data"}, got_q[i].d, exp_q[i].d);
        end
        chk({name, "_done"}, done_cnt - done_base, m_cap);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_ovf"}, ovf, m_ovf);
        chk({name, "_err"}, err, m_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1c;
        int d0;
        int nl;

        // reset state
        idle(3);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", addr_in, 0);
        chk("rst_data", data_in, 0);
        rst = 1'b1;
        idle(2);

        // reset asserted mid-line clears outputs at once; no capture until a fresh vsync fall
        frame_begin(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = 8'($urandom);
        end
        chk("midrst_busy_pre", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_regwrite", regwrite, 0);
        chk("midrst_addr", addr_in, 0);
        chk("midrst_data", data_in, 0);
        got_q.delete();
        @(negedge clk);
        rst = 1'b1;
        m_cap = 0;
        m_err = 0;
        m_ovf = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cam_data = 8'($urandom);
        end
        @(negedge clk);
        cam_href = 1'b0;
        idle(4);
        send_line(8, -1, -1, b1c);
        frame_end("midrst");
        chk("midrst_nowr", got_q.size(), 0);

        // single frame, first pair E7/18 packs to FF, with write latency check
        frame_begin(1);
        send_line(8, 'hE7, 'h18, b1c);
        send_line(8, -1, -1, nl);
        frame_end("single");
`ifdef CAM_FRAME_WRITER_TESTPAT_EN
        d0 = 0;
`else
        d0 = 'hFF;
`endif
        chk("single_d0", (got_q.size() > 0) ? got_q[0].d : -1, d0);
        chk("single_lat", (got_q.size() > 0) ? got_q[0].c : -1, b1c + 3);

        // overflow: 3 lines of 10 bytes into a 4x2 buffer
        frame_begin(1);
        for (int l = 0; l < 3; l++) send_line(10, -1, -1, b1c);
        frame_end("ovf");

        // odd byte count
        frame_begin(1);
        send_line(7, -1, -1, b1c);
        send_line(8, -1, -1, b1c);
        frame_end("odd");

        // gating by cap_en at frame start, then a normal capture
        frame_begin(0);
        send_line(8, -1, -1, b1c);
        send_line(8, -1, -1, b1c);
        frame_end("gated");
        frame_begin(1);
        send_line(8, -1, -1, b1c);
        send_line(8, -1, -1, b1c);
        frame_end("regated");

        // random frames, cap_en also toggled mid-frame
        for (int f = 0; f < 10; f++) begin
            frame_begin($urandom_range(0, 3) != 0);
            cap_en = 1'($urandom_range(0, 1));
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) send_line($urandom_range(1, 12), -1, -1, b1c);
            frame_end($sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
